// File: rtl/img_pkg.sv
// Shared definitions for the zoom address path: mode encodings, default
// geometry and the mode -> {direction, shift} decode.
package img_pkg;

  localparam logic [2:0] MODE_1X   = 3'b000;
  localparam logic [2:0] MODE_2X   = 3'b001;
  localparam logic [2:0] MODE_4X   = 3'b010;
  localparam logic [2:0] MODE_DIV2 = 3'b011;
  localparam logic [2:0] MODE_DIV4 = 3'b100;

  localparam int unsigned IMG_W_DEF = 160;
  localparam int unsigned IMG_H_DEF = 120;
  localparam int unsigned SCR_W_DEF = 640;
  localparam int unsigned SCR_H_DEF = 480;

  // dir = 0: zoom in (replicate), dir = 1: zoom out (decimate)
  typedef struct packed {
    logic       dir;
    logic [1:0] s;
  } zoom_t;

  function automatic zoom_t zoom_shift(input logic [2:0] mode);
    zoom_t z;
    unique case (mode)
      MODE_2X:   z = '{dir: 1'b0, s: 2'd1};
      MODE_4X:   z = '{dir: 1'b0, s: 2'd2};
      MODE_DIV2: z = '{dir: 1'b1, s: 2'd1};
      MODE_DIV4: z = '{dir: 1'b1, s: 2'd2};
      default:   z = '{dir: 1'b0, s: 2'd0};
    endcase
    return z;
  endfunction

  // Unused encodings collapse to 1x so active_mode always shows what is applied.
  function automatic logic [2:0] mode_norm(input logic [2:0] mode);
    return (mode > MODE_DIV4) ? MODE_1X : mode;
  endfunction

endpackage

// File: rtl/zoom_addr_gen.sv
// Combinational display geometry (size, centring offsets, in-image test,
// source coordinates) plus the registered memory address.
// Ports: clock/reset (sync, active-high); mode (effective mode for this pixel);
//   next_x/next_y (VGA coordinate); in_image (comb, same cycle);
//   address/mem_rd_en (registered one cycle after the coordinate).
module zoom_addr_gen
  import img_pkg::*;
#(
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF,
  parameter int unsigned SCR_W  = SCR_W_DEF,
  parameter int unsigned SCR_H  = SCR_H_DEF,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        mode,
  input  logic [9:0]        next_x,
  input  logic [9:0]        next_y,
  output logic              in_image,
  output logic [ADDR_W-1:0] address,
  output logic              mem_rd_en
);

  zoom_t             z;
  logic [31:0]       dw, dh, x0, y0, xs, ys, rx, ry, ix, iy;
  logic [ADDR_W-1:0] addr_d;

  always_comb begin
    z  = zoom_shift(mode);
    dw = z.dir ? (IMG_W >> z.s) : (IMG_W << z.s);
    dh = z.dir ? (IMG_H >> z.s) : (IMG_H << z.s);
    if (dw > SCR_W) dw = SCR_W;
    if (dh > SCR_H) dh = SCR_H;
    x0 = (SCR_W - dw) >> 1;
    y0 = (SCR_H - dh) >> 1;
    xs = 32'(next_x);
    ys = 32'(next_y);
    // Blanking coordinates are rejected before the window test.
    in_image = (xs < SCR_W) && (ys < SCR_H) &&
               (xs >= x0) && (xs < x0 + dw) &&
               (ys >= y0) && (ys < y0 + dh);
    rx = xs - x0;
    ry = ys - y0;
    ix = z.dir ? (rx << z.s) : (rx >> z.s);
    iy = z.dir ? (ry << z.s) : (ry >> z.s);
    addr_d = ADDR_W'(iy) * ADDR_W'(IMG_W) + ADDR_W'(ix);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      address   <= '0;
      mem_rd_en <= 1'b0;
    end else begin
      mem_rd_en <= in_image;
      if (in_image) address <= addr_d;
    end
  end

endmodule

// File: rtl/img_zoom_engine.sv
// Pixel address path between the VGA controller and the image memory with
// power-of-two zoom in/out, centring and frame-aligned mode switching.
// Ports: clock, reset (sync, active-high); chaves (async mode switches);
//   next_x/next_y (coordinate, leads colour by 2+MEM_LATENCY cycles);
//   address/mem_rd_en (to memory); pixel_in (memory q); color_out (to VGA);
//   active_mode (mode applied); mode_changed (1-cycle pulse on update).
module img_zoom_engine
  import img_pkg::*;
#(
  parameter int unsigned IMG_W        = IMG_W_DEF,
  parameter int unsigned IMG_H        = IMG_H_DEF,
  parameter int unsigned SCR_W        = SCR_W_DEF,
  parameter int unsigned SCR_H        = SCR_H_DEF,
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned PIX_W        = 8,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter logic [PIX_W-1:0] BORDER_COLOR = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        chaves,
  input  logic [9:0]        next_x,
  input  logic [9:0]        next_y,
  output logic [ADDR_W-1:0] address,
  output logic              mem_rd_en,
  input  logic [PIX_W-1:0]  pixel_in,
  output logic [PIX_W-1:0]  color_out,
  output logic [2:0]        active_mode,
  output logic              mode_changed
);

  logic [2:0]           sync1_q, sync2_q, pending_q, active_q;
  logic [MEM_LATENCY:0] vld_q;
  logic                 frame_start, in_image;
  logic [2:0]           eff_mode;

  // The first pixel of a frame is already addressed with the new mode.
  assign frame_start = (next_x == 10'd0) && (next_y == 10'd0);
  assign eff_mode    = frame_start ? pending_q : active_q;
  assign active_mode = active_q;

  zoom_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .SCR_W  (SCR_W),
    .SCR_H  (SCR_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clock     (clock),
    .reset     (reset),
    .mode      (eff_mode),
    .next_x    (next_x),
    .next_y    (next_y),
    .in_image  (in_image),
    .address   (address),
    .mem_rd_en (mem_rd_en)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q      <= MODE_1X;
      sync2_q      <= MODE_1X;
      pending_q    <= MODE_1X;
      active_q     <= MODE_1X;
      mode_changed <= 1'b0;
      vld_q        <= '0;
      color_out    <= BORDER_COLOR;
    end else begin
      sync1_q      <= chaves;
      sync2_q      <= sync1_q;
      pending_q    <= mode_norm(sync2_q);
      mode_changed <= frame_start && (pending_q != active_q);
      if (frame_start) active_q <= pending_q;
      // Validity travels with the pixel through address register + memory;
      // it is not flushed on a mode change so the old frame drains cleanly.
      vld_q        <= {vld_q[MEM_LATENCY-1:0], in_image};
      color_out    <= vld_q[MEM_LATENCY] ? pixel_in : BORDER_COLOR;
    end
  end

endmodule

// File: tb/tb_img_zoom_engine.sv
module tb_img_zoom_engine;
  localparam int LAT = 1;
  localparam int IMG_W = 160, IMG_H = 120, SCR_W = 640, SCR_H = 480;
  localparam logic [7:0] BORDER = 8'h00;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  chaves;
  logic [9:0]  next_x, next_y;
  logic [16:0] address;
  logic        mem_rd_en;
  logic [7:0]  pixel_in, color_out;
  logic [2:0]  active_mode;
  logic        mode_changed;

  int checks = 0, passed = 0;

  img_zoom_engine #(
    .IMG_W (IMG_W), .IMG_H (IMG_H), .SCR_W (SCR_W), .SCR_H (SCR_H),
    .ADDR_W (17), .PIX_W (8), .MEM_LATENCY (LAT), .BORDER_COLOR (BORDER)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .chaves       (chaves),
    .next_x       (next_x),
    .next_y       (next_y),
    .address      (address),
    .mem_rd_en    (mem_rd_en),
    .pixel_in     (pixel_in),
    .color_out    (color_out),
    .active_mode  (active_mode),
    .mode_changed (mode_changed)
  );

  always #20 clock = ~clock;

  function automatic logic [7:0] mem_fn(input int a);
    return 8'(a * 7) | 8'h01;
  endfunction

  // Memory with LAT cycles read latency
  logic [7:0] mem_pipe [LAT];
  always @(posedge clock) begin
    mem_pipe[0] <= mem_fn(int'(address));
    for (int i = 1; i < LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign pixel_in = mem_pipe[LAT-1];

  // Reference: display window scaled by factor f, source pixel by division/multiplication
  function automatic void ref_map(input int mode, input int x, input int y,
                                  output bit ins, output int a);
    int f, dw, dh, x0, y0;
    bit zin;
    case ((mode > 4) ? 0 : mode)
      1:       begin zin = 1; f = 2; end
      2:       begin zin = 1; f = 4; end
      3:       begin zin = 0; f = 2; end
      4:       begin zin = 0; f = 4; end
      default: begin zin = 1; f = 1; end
    endcase
    dw = zin ? IMG_W * f : IMG_W / f;
    dh = zin ? IMG_H * f : IMG_H / f;
    if (dw > SCR_W) dw = SCR_W;
    if (dh > SCR_H) dh = SCR_H;
    x0 = (SCR_W - dw) / 2;
    y0 = (SCR_H - dh) / 2;
    ins = x < SCR_W && y < SCR_H && x >= x0 && x < x0 + dw && y >= y0 && y < y0 + dh;
    a = 0;
    if (ins) begin
      if (zin) a = ((y - y0) / f) * IMG_W + (x - x0) / f;
      else     a = ((y - y0) * f) * IMG_W + (x - x0) * f;
    end
  endfunction

  // Model state
  int         model_mode, last_addr;
  logic [7:0] hist [LAT+2];
  bit         exp_en;
  int         exp_addr;
  logic [7:0] exp_col;

  task automatic clear_model();
    model_mode = 0;
    last_addr  = 0;
    for (int i = 0; i < LAT + 2; i++) hist[i] = BORDER;
  endtask

  // Drive one coordinate, advance one clock, publish model expectations
  task automatic tick(input int x, input int y);
    bit ins;
    int a;
    next_x = 10'(x);
    next_y = 10'(y);
    if (x == 0 && y == 0) model_mode = (chaves > 3'd4) ? 0 : int'(chaves);
    ref_map(model_mode, x, y, ins, a);
    if (ins) last_addr = a;
    for (int i = LAT + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = ins ? mem_fn(last_addr) : BORDER;
    @(posedge clock); #1;
    exp_en   = ins;
    exp_addr = last_addr;
    exp_col  = hist[LAT+1];
  endtask

  task automatic set_mode(input logic [2:0] m);
    chaves = m;
    repeat (5) tick(700, 500);
    tick(0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1; chaves = 3'b000; next_x = 10'd700; next_y = 10'd500;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (address !== 17'd0) $display("FAIL reset_address got %0d want 0", address); else passed++;
    checks++; if (mem_rd_en !== 1'b0) $display("FAIL reset_rd_en got %0b want 0", mem_rd_en); else passed++;
    checks++; if (color_out !== BORDER) $display("FAIL reset_color got %0h want %0h", color_out, BORDER); else passed++;
    checks++; if (active_mode !== 3'b000) $display("FAIL reset_mode got %0b want 000", active_mode); else passed++;
    checks++; if (mode_changed !== 1'b0) $display("FAIL reset_changed got %0b want 0", mode_changed); else passed++;
    reset = 1'b0;
    clear_model();
  endtask

  task automatic test_1x();
    set_mode(3'b000);
    tick(240, 180);
    checks++; if (address !== 17'd0 || mem_rd_en !== 1'b1)
      $display("FAIL 1x_first got addr %0d en %0b want 0 1", address, mem_rd_en); else passed++;
    tick(399, 299);
    checks++; if (address !== 17'd19199) $display("FAIL 1x_last got %0d want 19199", address); else passed++;
    tick(239, 180);
    checks++; if (mem_rd_en !== 1'b0 || address !== 17'd19199)
      $display("FAIL 1x_left got en %0b addr %0d want 0 19199", mem_rd_en, address); else passed++;
    checks++; if (color_out !== mem_fn(0)) $display("FAIL 1x_col0 got %0h want %0h", color_out, mem_fn(0)); else passed++;
    tick(700, 500);
    checks++; if (color_out !== mem_fn(19199))
      $display("FAIL 1x_col1 got %0h want %0h", color_out, mem_fn(19199)); else passed++;
    tick(700, 500);
    checks++; if (color_out !== BORDER) $display("FAIL 1x_border got %0h want %0h", color_out, BORDER); else passed++;
  endtask

  task automatic test_4x();
    set_mode(3'b010);
    checks++; if (active_mode !== 3'b010 || address !== 17'd0 || mem_rd_en !== 1'b1)
      $display("FAIL 4x_origin got mode %0b addr %0d en %0b want 010 0 1", active_mode, address, mem_rd_en);
    else passed++;
    tick(3, 3);
    checks++; if (address !== 17'd0) $display("FAIL 4x_3_3 got %0d want 0", address); else passed++;
    tick(4, 0);
    checks++; if (address !== 17'd1) $display("FAIL 4x_4_0 got %0d want 1", address); else passed++;
    tick(639, 479);
    checks++; if (address !== 17'd19199 || mem_rd_en !== 1'b1)
      $display("FAIL 4x_corner got addr %0d en %0b want 19199 1", address, mem_rd_en); else passed++;
  endtask

  task automatic test_div2();
    set_mode(3'b011);
    tick(281, 211);
    checks++; if (address !== 17'd322 || mem_rd_en !== 1'b1)
      $display("FAIL div2_in got addr %0d en %0b want 322 1", address, mem_rd_en); else passed++;
    tick(360, 210);
    checks++; if (mem_rd_en !== 1'b0) $display("FAIL div2_right got en %0b want 0", mem_rd_en); else passed++;
  endtask

  task automatic test_mode_change();
    set_mode(3'b000);
    tick(100, 100);
    chaves = 3'b001;
    for (int i = 0; i < 5; i++) begin
      tick(100 + i, 100);
      checks++; if (active_mode !== 3'b000 || mode_changed !== 1'b0)
        $display("FAIL chg_hold%0d got mode %0b pulse %0b want 000 0", i, active_mode, mode_changed);
      else passed++;
    end
    tick(0, 0);
    checks++; if (active_mode !== 3'b001 || mode_changed !== 1'b1 || mem_rd_en !== 1'b0)
      $display("FAIL chg_apply got mode %0b pulse %0b en %0b want 001 1 0",
               active_mode, mode_changed, mem_rd_en);
    else passed++;
    tick(1, 0);
    checks++; if (mode_changed !== 1'b0) $display("FAIL chg_pulse got %0b want 0", mode_changed); else passed++;
    tick(160, 120);
    checks++; if (address !== 17'd0 || mem_rd_en !== 1'b1)
      $display("FAIL chg_2x_origin got addr %0d en %0b want 0 1", address, mem_rd_en); else passed++;
  endtask

  task automatic test_random();
    int x, y;
    for (int m = 0; m < 8; m++) begin
      set_mode(3'(m));
      for (int n = 0; n < 50; n++) begin
        if ($urandom_range(1, 0) == 1) begin
          x = int'($urandom_range(519, 120)); y = int'($urandom_range(389, 90));
        end else begin
          x = int'($urandom_range(799, 0)); y = int'($urandom_range(524, 0));
        end
        tick(x, y);
        checks++; if (mem_rd_en !== exp_en || address !== 17'(exp_addr))
          $display("FAIL rnd_addr m%0d (%0d,%0d) got en %0b addr %0d want %0b %0d",
                   m, x, y, mem_rd_en, address, exp_en, exp_addr);
        else passed++;
        checks++; if (color_out !== exp_col)
          $display("FAIL rnd_color m%0d got %0h want %0h", m, color_out, exp_col);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    set_mode(3'b010);
    tick(100, 50);
    tick(101, 50);
    reset  = 1'b1;
    chaves = 3'b000;
    @(posedge clock); #1;
    checks++; if (active_mode !== 3'b000 || color_out !== BORDER || mem_rd_en !== 1'b0 || address !== 17'd0)
      $display("FAIL midreset got mode %0b col %0h en %0b addr %0d want 000 %0h 0 0",
               active_mode, color_out, mem_rd_en, address, BORDER);
    else passed++;
    reset = 1'b0;
    clear_model();
    for (int i = 0; i < 3; i++) begin
      tick(700, 500);
      checks++; if (color_out !== BORDER) $display("FAIL midreset_drain%0d got %0h want %0h", i, color_out, BORDER);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_1x();
    test_4x();
    test_div2();
    test_mode_change();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
